cpu_core_axi_master: RTL and testbench

//  AXI4-Lite initiator for the CPU core: turns the core's one-shot memory request port into AXI4-Lite

---
 rtl/cpu_core_axi_master.sv | 195 +++++++++++++++++++
 tb/tb_cpu_core_axi_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_axi_master.sv
// rtl/cpu_core_axi_master.sv - AXI4-Lite initiator for the CPU core one-shot memory request port
//
// Accepts one core request at a time (REQ_VALID/REQ_READY), issues it as a single AXI4-Lite
// read or write, and reports completion with a one-cycle RESP_VALID pulse carrying read data and
// an error flag (BRESP/RRESP bit 1). RD_CNT/WR_CNT count completed transactions and wrap.
// Ports:
//   m_axi_aclk, m_axi_aresetn          clock, asynchronous active-low reset
//   REQ_*                              core request side
//   RESP_*, RD_CNT, WR_CNT             completion and statistics
//   m_axi_aw*/w*/b*/ar*/r*             AXI4-Lite master channels
module cpu_core_axi_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic                              REQ_WE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     REQ_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   REQ_WSTRB,
  output logic                              RESP_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     RESP_RDATA,
  output logic                              RESP_ERR,
  output logic [31:0]                       RD_CNT,
  output logic [31:0]                       WR_CNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DW-1:0]     resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  // Handshake events seen this cycle in the current state
  logic aw_hs, w_hs, aw_all, w_all;

  // Sub-word address bits and the low response bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{REQ_ADDR[1:0], m_axi_bresp[0], m_axi_rresp[0]};

  // State and datapath registers
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  // A channel is finished if it completed earlier or completes now
  assign aw_all = aw_done_q || aw_hs;
  assign w_all  = w_done_q || w_hs;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (REQ_VALID) state_d = REQ_WE ? S_WRITE : S_RADDR;
      S_WRITE: if (aw_all && w_all) state_d = S_WRESP;
      S_WRESP: if (m_axi_bvalid) state_d = S_IDLE;
      S_RADDR: if (m_axi_arready) state_d = S_RDATA;
      S_RDATA: if (m_axi_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: request capture, channel done flags, response and counters
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          addr_d    = {REQ_ADDR[AW-1:2], 2'b00};
          wdata_d   = REQ_WDATA;
          wstrb_d   = REQ_WSTRB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WRITE: begin
        // Flags clear on leaving so the next write starts with both channels pending
        aw_done_d = aw_all && !w_all;
        w_done_d  = w_all && !aw_all;
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = m_axi_bresp[1];
          wr_cnt_d     = wr_cnt_q + 32'd1;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = m_axi_rdata;
          resp_err_d   = m_axi_rresp[1];
          rd_cnt_d     = rd_cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: channel valids/readys decode straight from state so reset drops them at once
  always_comb begin
    REQ_READY     = (state_q == S_IDLE);
    m_axi_awvalid = (state_q == S_WRITE) && !aw_done_q;
    m_axi_wvalid  = (state_q == S_WRITE) && !w_done_q;
    m_axi_bready  = (state_q == S_WRESP);
    m_axi_arvalid = (state_q == S_RADDR);
    m_axi_rready  = (state_q == S_RDATA);
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign RESP_VALID   = resp_valid_q;
  assign RESP_RDATA   = resp_rdata_q;
  assign RESP_ERR     = resp_err_q;
  assign RD_CNT       = rd_cnt_q;
  assign WR_CNT       = wr_cnt_q;

endmodule

// File: tb/tb_cpu_core_axi_master.sv
// tb/tb_cpu_core_axi_master.sv - directed self-checking bench for cpu_core_axi_master
module tb_cpu_core_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [3:0]  REQ_WSTRB;
  logic        RESP_VALID, RESP_ERR;
  logic [31:0] RESP_RDATA, RD_CNT, WR_CNT;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_wr = 32'd0;
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;

  cpu_core_axi_master dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
    .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
    .RD_CNT(RD_CNT), .WR_CNT(WR_CNT),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write with awready raised aw_wait cycles and wready w_wait cycles after the valids appear
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_wait, input int w_wait,
                          input logic [1:0] bresp);
    int k;
    logic aw_hs, w_hs;
    @(negedge clk);
    chk({tag, ".req_ready"}, REQ_READY, 1);
    REQ_VALID = 1; REQ_WE = 1; REQ_ADDR = addr; REQ_WDATA = data; REQ_WSTRB = strb;
    @(negedge clk);
    REQ_VALID = 0;
    k = 0; aw_hs = 0; w_hs = 0;
    while (!m_axi_bready && k < 50) begin
      chk({tag, ".valids"}, {m_axi_awvalid, m_axi_wvalid}, {!aw_hs, !w_hs});
      chk({tag, ".awaddr"}, m_axi_awaddr, {addr[31:2], 2'b00});
      chk({tag, ".wdata"}, m_axi_wdata, data);
      chk({tag, ".wstrb"}, m_axi_wstrb, strb);
      chk({tag, ".early_resp"}, RESP_VALID, 0);
      m_axi_awready = (k == aw_wait);
      m_axi_wready  = (k == w_wait);
      @(negedge clk);
      if (k == aw_wait) aw_hs = 1;
      if (k == w_wait) w_hs = 1;
      k++;
    end
    m_axi_awready = 0; m_axi_wready = 0;
    chk({tag, ".b_cycle"}, k, ((aw_wait > w_wait) ? aw_wait : w_wait) + 1);
    chk({tag, ".valids_off"}, {m_axi_awvalid, m_axi_wvalid}, 0);
    m_axi_bvalid = 1; m_axi_bresp = bresp;
    @(negedge clk);
    m_axi_bvalid = 0; m_axi_bresp = 0;
    exp_wr = exp_wr + 1;
    chk({tag, ".resp_valid"}, RESP_VALID, 1);
    chk({tag, ".resp_err"}, RESP_ERR, bresp[1]);
    chk({tag, ".wr_cnt"}, WR_CNT, exp_wr);
    chk({tag, ".bready_off"}, m_axi_bready, 0);
    @(negedge clk);
    chk({tag, ".resp_pulse"}, RESP_VALID, 0);
  endtask

  // Read with arready raised after ar_wait cycles and rvalid after r_wait cycles of rready
  task automatic do_read(input string tag, input logic [31:0] addr, input int ar_wait,
                         input int r_wait, input logic [31:0] rdata, input logic [1:0] rresp);
    int k;
    @(negedge clk);
    chk({tag, ".req_ready"}, REQ_READY, 1);
    REQ_VALID = 1; REQ_WE = 0; REQ_ADDR = addr;
    @(negedge clk);
    REQ_VALID = 0;
    k = 0;
    while (!m_axi_rready && k < 50) begin
      chk({tag, ".arvalid"}, m_axi_arvalid, 1);
      chk({tag, ".araddr"}, m_axi_araddr, {addr[31:2], 2'b00});
      m_axi_arready = (k == ar_wait);
      @(negedge clk);
      k++;
    end
    m_axi_arready = 0;
    chk({tag, ".arvalid_cycles"}, k, ar_wait + 1);
    chk({tag, ".arvalid_off"}, m_axi_arvalid, 0);
    for (int i = 0; i < r_wait; i++) begin
      chk({tag, ".rready_wait"}, m_axi_rready, 1);
      chk({tag, ".early_resp"}, RESP_VALID, 0);
      @(negedge clk);
    end
    m_axi_rvalid = 1; m_axi_rdata = rdata; m_axi_rresp = rresp;
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    exp_rd = exp_rd + 1;
    chk({tag, ".resp_valid"}, RESP_VALID, 1);
    chk({tag, ".rdata"}, RESP_RDATA, rdata);
    chk({tag, ".resp_err"}, RESP_ERR, rresp[1]);
    chk({tag, ".rd_cnt"}, RD_CNT, exp_rd);
    @(negedge clk);
    chk({tag, ".resp_pulse"}, RESP_VALID, 0);
  endtask

  initial begin
    rst_n = 0;
    REQ_VALID = 0; REQ_WE = 0; REQ_ADDR = 0; REQ_WDATA = 0; REQ_WSTRB = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    repeat (2) @(negedge clk);
    chk("rst.valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst.resp", {RESP_VALID, RESP_ERR}, 0);
    chk("rst.rdata", RESP_RDATA, 0);
    chk("rst.rd_cnt", RD_CNT, 0);
    chk("rst.wr_cnt", WR_CNT, 0);
    chk("rst.req_ready", REQ_READY, 1);
    chk("rst.prot", {m_axi_awprot, m_axi_arprot}, 0);
    rst_n = 1;

    // 1: zero-wait write, RESP_VALID at c3
    do_write("t1_write", 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00);

    // 2: read of unaligned address, five arready waits
    do_read("t2_read", 32'h0000_2003, 5, 0, 32'h1234_5678, 2'b00);

    // 3: W before AW, AW before W, both together
    do_write("t3_w_first", 32'h0000_3010, 32'hA5A5_0001, 4'h3, 3, 0, 2'b00);
    do_write("t3_aw_first", 32'h0000_3020, 32'hA5A5_0002, 4'hC, 0, 3, 2'b00);
    do_write("t3_same", 32'h0000_3032, 32'hA5A5_0003, 4'h1, 2, 2, 2'b00);
    chk("t3.rdata_held", RESP_RDATA, 32'h1234_5678);

    // 4: error responses still count
    do_read("t4_rd_err", 32'h0000_7000, 0, 2, 32'hBAD0_BAD0, 2'b10);
    do_write("t4_wr_err", 32'h0000_7004, 32'h0000_0055, 4'hF, 1, 0, 2'b11);

    // 5: reset while waiting in WRESP
    @(negedge clk);
    REQ_VALID = 1; REQ_WE = 1; REQ_ADDR = 32'h0000_3000; REQ_WDATA = 32'h1; REQ_WSTRB = 4'hF;
    m_axi_awready = 1; m_axi_wready = 1;
    @(negedge clk);
    REQ_VALID = 0;
    @(negedge clk);
    m_axi_awready = 0; m_axi_wready = 0;
    chk("t5.in_wresp", m_axi_bready, 1);
    rst_n = 0;
    #1;
    chk("t5.valids_low", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("t5.wr_cnt", WR_CNT, 0);
    chk("t5.rd_cnt", RD_CNT, 0);
    chk("t5.rdata", RESP_RDATA, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5.no_resp", RESP_VALID, 0);
    end
    rst_n = 1;
    exp_wr = 0; exp_rd = 0;
    @(negedge clk);
    chk("t5.no_resp_after", RESP_VALID, 0);
    do_read("t5_read", 32'h0000_4004, 1, 1, 32'h0BAD_F00D, 2'b00);

    // 6: write counter wrap
    @(negedge clk);
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.wr_cnt_q;
    chk("t6.preload", WR_CNT, 32'hFFFF_FFFF);
    exp_wr = 32'hFFFF_FFFF;
    do_write("t6_wrap", 32'h0000_5000, 32'h0000_00AA, 4'hF, 0, 0, 2'b00);
    chk("t6.wr_cnt_zero", WR_CNT, 0);

    // 6: back-to-back, read accepted in the write's RESP_VALID cycle
    @(negedge clk);
    REQ_VALID = 1; REQ_WE = 1; REQ_ADDR = 32'h0000_5004; REQ_WDATA = 32'h77; REQ_WSTRB = 4'hF;
    m_axi_awready = 1; m_axi_wready = 1;
    @(negedge clk);
    REQ_VALID = 0;
    @(negedge clk);
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    @(negedge clk);
    m_axi_bvalid = 0;
    chk("t6b.resp_and_ready", {RESP_VALID, REQ_READY}, 2'b11);
    chk("t6b.wr_cnt", WR_CNT, 1);
    REQ_VALID = 1; REQ_WE = 0; REQ_ADDR = 32'h0000_6008;
    @(negedge clk);
    REQ_VALID = 0;
    chk("t6b.arvalid", m_axi_arvalid, 1);
    chk("t6b.araddr", m_axi_araddr, 32'h0000_6008);
    chk("t6b.resp_pulse", RESP_VALID, 0);
    m_axi_arready = 1;
    @(negedge clk);
    m_axi_arready = 0;
    chk("t6b.rready", m_axi_rready, 1);
    m_axi_rvalid = 1; m_axi_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    m_axi_rvalid = 0;
    chk("t6b.rd_resp", RESP_VALID, 1);
    chk("t6b.rd_data", RESP_RDATA, 32'hCAFE_F00D);
    chk("t6b.rd_cnt", RD_CNT, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
